q_fetch_unit: RTL and testbench
===============================

# q_fetch_unit

Read-side companion to the Q-value update datapath. For each learning step it reads the Q-table, fetching `old_Q` for the current (state, action) pair and scanning every action of the next state for `max_Q` and the greedy `max_action`. It then presents these to the Q-update stage over a valid/ready handshake. It sits between the agent/environment controller and the synchronous Q-table RAM, upstream of the updater that produces `new_Q`.

## Interface
Parameters:
- `N_STATES`, 16: number of states; power of two.
- `N_ACTIONS`, 4: actions per state; power of two, at least 2.
- `Q_W`, 16: Q-value width, unsigned.
- `A_W`, `$clog2(N_STATES*N_ACTIONS)`: RAM address width (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `cur_state` in `$clog2(N_STATES)`: current state.
- `cur_action` in `$clog2(N_ACTIONS)`: action taken.
- `next_state` in `$clog2(N_STATES)`: resulting state.
- `mem_rd_en` out 1: RAM read enable.
- `mem_addr` out `A_W`: RAM address, `state*N_ACTIONS + action`.
- `mem_rdata` in `Q_W`: RAM data, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `old_Q` out `Q_W`: Q(cur_state, cur_action).
- `max_Q` out `Q_W`: max over a of Q(next_state, a).
- `max_action` out `$clog2(N_ACTIONS)`: argmax action.

## Operation
- FSM states: IDLE, RD_OLD, RD_ROW, DRAIN, DONE.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`&`req_ready`. On acceptance, `cur_state`, `cur_action` and `next_state` are latched and the FSM moves to RD_OLD.
- RD_OLD: issues a read of the (cur_state, cur_action) address, then moves to RD_ROW.
- RD_ROW: issues reads of (next_state, 0..N_ACTIONS-1) on consecutive cycles, with one read per cycle and no bubbles. After action N_ACTIONS-1 it moves to DRAIN.
- Data capture: the first returned word loads `old_Q`. Row words update the running max.
- Running max: the first row word initialises `max_Q`/`max_action`. Each later word replaces them only if it is strictly greater, so ties keep the lowest action index.
- Comparison is unsigned, `Q_W` bits; there is no arithmetic beyond compare.
- DRAIN: captures the last row word, then moves to DONE.
- DONE: `out_valid`=1. Outputs stay stable until `out_ready`. On `out_valid`&`out_ready` the FSM returns to IDLE.
- The row may include (cur_state, cur_action) when next_state equals cur_state. No special case applies; the same word is read twice.
- `mem_rd_en`=0 and `mem_addr` holds its last value outside RD_OLD/RD_ROW.
- Requests presented while busy are ignored, because `req_ready` is 0.
- Reset, asynchronous at any point including mid-scan, returns the FSM to IDLE. Reset values: `out_valid`=0, `req_ready`=1 once `rst_n` deasserts, `mem_rd_en`=0, `mem_addr`=0, `old_Q`=0, `max_Q`=0, `max_action`=0. In-flight RAM data is discarded.

## Timing
- Accept edge = cycle 0.
- `mem_rd_en` is high on cycles 1 through N_ACTIONS+1. The old_Q read is on cycle 1 and the row reads are on cycles 2..N_ACTIONS+1.
- The last datum is captured at the end of cycle N_ACTIONS+2.
- `out_valid` is high from cycle N_ACTIONS+3 until the handshake.
- Minimum request-to-request spacing is N_ACTIONS+4 cycles, with `out_ready` tied high. With N_ACTIONS=4 that is 8 cycles.
- `req_ready` returns high the cycle after the output handshake.

## Configuration
- `QFETCH_EXPLORE_EN` defined: adds input `epsilon` [7:0] and output `explore` [0:0], plus a 16-bit Galois LFSR.
  - The LFSR uses taps 0xB400 and seed 0xACE1 on reset, and advances every cycle.
  - On entry to DONE, if `lfsr[7:0] < epsilon` then `max_action` = `lfsr[8 +: $clog2(N_ACTIONS)]` and `explore`=1. Otherwise `explore`=0.
  - `max_Q` is always the true maximum (off-policy).
- Not defined: no extra ports and no LFSR; `max_action` is always greedy.

## Structure
- Shared package `q_pkg`:
  - `Q_W` default.
  - FSM state enum `qfetch_state_t`.
  - Address-compose function `q_addr(state, action)`.
  - LFSR seed/taps constants.
- Sub-module `q_lfsr16` (enable, seed-on-reset) is instantiated only under `QFETCH_EXPLORE_EN`.
- Scan datapath and FSM stay in `q_fetch_unit`.

## Test plan
- Reset mid-scan: assert `rst_n`=0 during RD_ROW -> all outputs at reset values immediately, `req_ready`=1 after release, no further `mem_rd_en`.
- Basic: the RAM row for next_state=3 is {10,50,20,30}, and Q(1,2)=7 -> `old_Q`=7, `max_Q`=50, `max_action`=1, `out_valid` on cycle 7.
- Tie and extreme values: row {0xFFFF,0xFFFF,0,0xFFFF} -> `max_Q`=0xFFFF, `max_action`=0. Row all zero -> `max_Q`=0, `max_action`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles -> outputs stable, `req_ready`=0, `req_valid` pulses ignored. Release -> one transfer, then IDLE.
- Address sequence: cur_state=15, cur_action=3, next_state=15 -> `mem_addr` sequence 63,60,61,62,63 on consecutive cycles.
- `QFETCH_EXPLORE_EN`: epsilon=0 -> `explore` never 1 over 100 requests. epsilon=255 -> `explore`=1 whenever `lfsr[7:0]`≠255, with `max_Q` still the true max.

Source files
------------

// File: rtl/q_pkg.sv
// Shared definitions for the Q-table fetch unit: FSM state encoding,
// Q-table address composition and exploration LFSR constants.
package q_pkg;

    localparam int Q_W_DEFAULT = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OLD,
        ST_RD_ROW,
        ST_DRAIN,
        ST_DONE
    } qfetch_state_t;

    // Row-major Q-table layout: all actions of a state are contiguous.
    function automatic int unsigned q_addr(input int unsigned state,
                                           input int unsigned action,
                                           input int unsigned n_actions);
        return state * n_actions + action;
    endfunction

endpackage

// File: rtl/q_lfsr16.sv
// 16-bit Galois LFSR used as the exploration random source.
// The whole module only exists when QFETCH_EXPLORE_EN is defined, so the
// default build carries no LFSR at all.
`ifdef QFETCH_EXPLORE_EN
module q_lfsr16
    import q_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] lfsr
);

    logic [15:0] r_lfsr;

    // Right-shifting Galois step; the bit shifted out selects the tap XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign lfsr = r_lfsr;

endmodule
`endif

// File: rtl/q_fetch_unit.sv
// Q-table read front end: fetches old_Q for (cur_state, cur_action), scans
// the next_state row for max_Q / greedy max_action, and hands the result to
// the Q-update stage over valid/ready.
// Optional epsilon-greedy exploration is compiled in with QFETCH_EXPLORE_EN.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | req_ready=1, waiting for a request
//  ST_RD_OLD | read Q(cur_state, cur_action)
//  ST_RD_ROW | read Q(next_state, 0..N_ACTIONS-1), one per cycle
//  ST_DRAIN  | no read; capture the last row word
//  ST_DONE   | out_valid=1, hold results until out_ready
module q_fetch_unit
    import q_pkg::*;
#(
    parameter int N_STATES  = 16,
    parameter int N_ACTIONS = 4,
    parameter int Q_W       = Q_W_DEFAULT,
    parameter int A_W       = $clog2(N_STATES * N_ACTIONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(N_STATES)-1:0]  cur_state,
    input  logic [$clog2(N_ACTIONS)-1:0] cur_action,
    input  logic [$clog2(N_STATES)-1:0]  next_state,
    output logic                         mem_rd_en,
    output logic [A_W-1:0]               mem_addr,
    input  logic [Q_W-1:0]               mem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [Q_W-1:0]               old_Q,
    output logic [Q_W-1:0]               max_Q,
    output logic [$clog2(N_ACTIONS)-1:0] max_action
`ifdef QFETCH_EXPLORE_EN
    ,
    input  logic [7:0]                   epsilon,
    output logic                         explore
`endif
);

    localparam int S_W  = $clog2(N_STATES);
    localparam int AC_W = $clog2(N_ACTIONS);
    localparam logic [AC_W-1:0] LAST_ACT = AC_W'(N_ACTIONS - 1);

    qfetch_state_t   r_state, w_state_nxt;
    logic [S_W-1:0]  r_cur_state, r_next_state;
    logic [AC_W-1:0] r_cur_action;
    logic [AC_W-1:0] r_act;
    logic [A_W-1:0]  r_addr_last;
    logic [Q_W-1:0]  r_old_q, r_max_q;
    logic [AC_W-1:0] r_max_action;
    logic [A_W-1:0]  w_old_addr, w_row_addr;
    logic            w_row_gt;

    assign w_old_addr = A_W'(q_addr(32'(r_cur_state), 32'(r_cur_action), N_ACTIONS));
    assign w_row_addr = A_W'(q_addr(32'(r_next_state), 32'(r_act), N_ACTIONS));
    assign w_row_gt   = (mem_rdata > r_max_q);

`ifdef QFETCH_EXPLORE_EN
    logic [15:0]     w_lfsr;
    logic            w_explore_hit;
    logic [AC_W-1:0] w_rand_action;
    logic            r_explore;

    q_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .lfsr  (w_lfsr)
    );

    assign w_explore_hit = (w_lfsr[7:0] < epsilon);
    assign w_rand_action = w_lfsr[8 +: AC_W];
    assign explore       = r_explore;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and RAM read issue; the address holds when idle.
    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        mem_addr    = r_addr_last;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_nxt = ST_RD_OLD;
            ST_RD_OLD: begin
                mem_rd_en   = 1'b1;
                mem_addr    = w_old_addr;
                w_state_nxt = ST_RD_ROW;
            end
            ST_RD_ROW: begin
                mem_rd_en = 1'b1;
                mem_addr  = w_row_addr;
                if (r_act == LAST_ACT) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  w_state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // Request latch, row action counter and last-issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_state  <= '0;
            r_cur_action <= '0;
            r_next_state <= '0;
            r_act        <= '0;
            r_addr_last  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                r_cur_state  <= cur_state;
                r_cur_action <= cur_action;
                r_next_state <= next_state;
            end
            if (r_state == ST_RD_ROW) r_act <= r_act + AC_W'(1);
            else                      r_act <= '0;
            if (mem_rd_en) r_addr_last <= mem_addr;
        end
    end

    // Data capture: word returning in RD_ROW with r_act==0 is old_Q; later
    // returns are row words r_act-1, and the final row word lands in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_old_q      <= '0;
            r_max_q      <= '0;
            r_max_action <= '0;
`ifdef QFETCH_EXPLORE_EN
            r_explore    <= 1'b0;
`endif
        end else begin
            if (r_state == ST_RD_ROW) begin
                if (r_act == '0) begin
                    r_old_q <= mem_rdata;
                end else if (r_act == AC_W'(1)) begin
                    r_max_q      <= mem_rdata;
                    r_max_action <= '0;
                end else if (w_row_gt) begin
                    r_max_q      <= mem_rdata;
                    r_max_action <= r_act - AC_W'(1);
                end
            end else if (r_state == ST_DRAIN) begin
                if (w_row_gt) begin
                    r_max_q      <= mem_rdata;
                    r_max_action <= LAST_ACT;
                end
`ifdef QFETCH_EXPLORE_EN
                // Exploration only overrides the reported action; max_Q stays
                // the true row maximum for the off-policy update.
                r_explore <= w_explore_hit;
                if (w_explore_hit) r_max_action <= w_rand_action;
`endif
            end
        end
    end

    assign old_Q      = r_old_q;
    assign max_Q      = r_max_q;
    assign max_action = r_max_action;

endmodule

// File: tb/tb_q_fetch_unit.sv
// Directed testbench for q_fetch_unit with a queue-based scoreboard: each
// request pushes its hand-computed result, a monitor pops on every output
// handshake.
module tb_q_fetch_unit;

    localparam int N_S = 16;
    localparam int N_A = 4;
    localparam int QW  = 16;
    localparam int AW  = 6;

    typedef struct packed {
        logic [QW-1:0] old_q;
        logic [QW-1:0] max_q;
        logic [1:0]    act;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    cur_state = '0;
    logic [1:0]    cur_action = '0;
    logic [3:0]    next_state = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [QW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] old_Q;
    logic [QW-1:0] max_Q;
    logic [1:0]    max_action;
`ifdef QFETCH_EXPLORE_EN
    logic [7:0]    epsilon = 8'd0;
    logic          explore;
`endif

    logic [QW-1:0] ram [0:63];
    exp_t          sb_q[$];
    exp_t          e;
    logic [AW-1:0] rd_addr_q[$];
    int            rd_cyc_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            hs_cnt = 0;

    q_fetch_unit #(.N_STATES(N_S), .N_ACTIONS(N_A), .Q_W(QW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .cur_state  (cur_state),
        .cur_action (cur_action),
        .next_state (next_state),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .old_Q      (old_Q),
        .max_Q      (max_Q),
        .max_action (max_action)
`ifdef QFETCH_EXPLORE_EN
        ,
        .epsilon    (epsilon),
        .explore    (explore)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: one-cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: log reads and score every output handshake.
    initial forever begin
        @(negedge clk);
        if (mem_rd_en) begin
            rd_addr_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got=handshake expected=none");
            end else begin
                e = sb_q.pop_front();
                check("sb_old_Q", old_Q, e.old_q);
                check("sb_max_Q", max_Q, e.max_q);
                check("sb_max_action", max_action, e.act);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_mem_rd_en"}, mem_rd_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_old_Q"}, old_Q, 0);
        check({tag, "_max_Q"}, max_Q, 0);
        check({tag, "_max_action"}, max_action, 0);
    endtask

    // Called just after a rising edge; returns the cycle stamp of the accept edge.
    task automatic do_req(input logic [3:0] cs, input logic [1:0] ca, input logic [3:0] ns,
                          input logic [QW-1:0] eo, input logic [QW-1:0] em, input logic [1:0] ea,
                          input bit push, output int acc);
        exp_t x;
        int w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_wait", req_ready, 1);
        cur_state  = cs;
        cur_action = ca;
        next_state = ns;
        req_valid  = 1'b1;
        x.old_q = eo;
        x.max_q = em;
        x.act   = ea;
        if (push) sb_q.push_back(x);
        rd_addr_q.delete();
        rd_cyc_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    // Cycle 1 is the cycle after the accept edge; out_valid must rise in cycle 7.
    task automatic wait_valid();
        int c = 1;
        while (c < 40) begin
            @(negedge clk);
            if (out_valid) break;
            c++;
        end
        check("out_valid_cycle", c, N_A + 3);
        @(posedge clk); #1;
    endtask

    task automatic check_reads(input logic [AW-1:0] ea [5], input int acc);
        check("rd_count", rd_addr_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rd_addr_q.size()) begin
                check("rd_addr", rd_addr_q[i], ea[i]);
                check("rd_cycle", rd_cyc_q[i], acc + i);
            end
        end
    endtask

    initial begin
        int acc, acc2, hs_before;
        logic [AW-1:0] ea [5];

        for (int i = 0; i < 64; i++) ram[i] = '0;
        ram[6] = 16'd7;
        ram[12] = 16'd10; ram[13] = 16'd50; ram[14] = 16'd20; ram[15] = 16'd30;
        ram[0] = 16'h1234;
        ram[20] = 16'hFFFF; ram[21] = 16'hFFFF; ram[22] = 16'h0000; ram[23] = 16'hFFFF;
        ram[9] = 16'hBEEF;
        ram[28] = 16'd1; ram[29] = 16'd2; ram[30] = 16'd3; ram[31] = 16'h8000;
        ram[60] = 16'd5; ram[61] = 16'd9; ram[62] = 16'd9; ram[63] = 16'd2;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("reset");

        // Basic: Q(1,2)=7, row 3 = {10,50,20,30}.
        do_req(4'd1, 2'd2, 4'd3, 16'd7, 16'd50, 2'd1, 1'b1, acc);
        wait_valid();
        ea = '{6'd6, 6'd12, 6'd13, 6'd14, 6'd15};
        check_reads(ea, acc);
        check("idle_after_hs_req_ready", req_ready, 1);
        check("idle_after_hs_out_valid", out_valid, 0);

        // Ties and extremes keep the lowest action.
        do_req(4'd0, 2'd0, 4'd5, 16'h1234, 16'hFFFF, 2'd0, 1'b1, acc2);
        check("req_spacing", acc2 - acc, N_A + 4);
        wait_valid();
        ea = '{6'd0, 6'd20, 6'd21, 6'd22, 6'd23};
        check_reads(ea, acc2);

        do_req(4'd2, 2'd1, 4'd6, 16'hBEEF, 16'h0000, 2'd0, 1'b1, acc);
        wait_valid();

        // Maximum in the last slot exercises the drain capture; row includes cur pair.
        do_req(4'd7, 2'd3, 4'd7, 16'h8000, 16'h8000, 2'd3, 1'b1, acc);
        wait_valid();

        // Top-of-table address sequence.
        do_req(4'd15, 2'd3, 4'd15, 16'd2, 16'd9, 2'd1, 1'b1, acc);
        wait_valid();
        ea = '{6'd63, 6'd60, 6'd61, 6'd62, 6'd63};
        check_reads(ea, acc);

        // Backpressure: result held, busy requests ignored.
        out_ready = 1'b0;
        do_req(4'd1, 2'd2, 4'd3, 16'd7, 16'd50, 2'd1, 1'b1, acc);
        wait_valid();
        hs_before = hs_cnt;
        rd_addr_q.delete();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_old_Q", old_Q, 16'd7);
            check("bp_max_Q", max_Q, 16'd50);
            check("bp_max_action", max_action, 2'd1);
            cur_state  = 4'd9;
            next_state = 4'd2;
            req_valid  = (i % 2 == 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("bp_no_hs", hs_cnt, hs_before);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_req_ready", req_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_one_transfer", hs_cnt, hs_before + 1);
        check("bp_no_reads", rd_addr_q.size(), 0);

        // Asynchronous reset while scanning the row.
        do_req(4'd1, 2'd2, 4'd3, 16'd0, 16'd0, 2'd0, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        hs_before = hs_cnt;
        rd_addr_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_reads", rd_addr_q.size(), 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_no_hs", hs_cnt, hs_before);

        // Recovery after reset.
        do_req(4'd15, 2'd3, 4'd15, 16'd2, 16'd9, 2'd1, 1'b1, acc);
        wait_valid();
        ea = '{6'd63, 6'd60, 6'd61, 6'd62, 6'd63};
        check_reads(ea, acc);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
